sram_march_bist: RTL and testbench
==================================

Name: sram_march_bist

Overview:
- Built-in self-test initiator that drives the single-port SRAM macro interface (we/wmask/addr/din in, dout out) and checks what comes back.
- Runs a March C- algorithm over the full address space and reports pass/fail plus first-failure diagnostics.
- Sits between the chip test controller (start/done handshake) and one SRAM instance.
- In functional mode the SRAM-side mux is outside this block.

Parameters:
- DATA_WIDTH, 32, SRAM word width.
- ADDR_WIDTH, 10, SRAM address width; depth N = 1<<ADDR_WIDTH.
- WMASK_WIDTH, 1, SRAM write-mask width; BIST always drives all ones.
- DATA_BG, 0 (DATA_WIDTH bits), data background: "0" = DATA_BG, "1" = ~DATA_BG.

Ports:
- clk  in  1  clock; same clock as the SRAM.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level-sampled; starts a run when idle.
- busy  out  1  high while a run is in progress.
- done  out  1  sticky high after a run ends, until the next accepted start or reset.
- fail  out  1  valid when done; 1 = mismatch found.
- fail_elem  out  3  March element index (0..5) of the first mismatch.
- fail_addr  out  ADDR_WIDTH  address of the first mismatching read.
- fail_data  out  DATA_WIDTH  dout value captured at the first mismatch.
- sram_we  out  1  registered SRAM write enable.
- sram_wmask  out  WMASK_WIDTH  registered SRAM write mask.
- sram_addr  out  ADDR_WIDTH  registered SRAM address.
- sram_din  out  DATA_WIDTH  registered SRAM write data.
- sram_dout  in  DATA_WIDTH  SRAM read data; valid the cycle after the SRAM's capture edge.

Behaviour:
- Reset values:
  - busy, done, fail, sram_we, sram_wmask = 0.
  - sram_addr, sram_din, fail_* = 0.
  - FSM in IDLE.
  - Compare pipeline flushed.
- March elements:
  - E0: up, w0.
  - E1: up, r0 w1.
  - E2: up, r1 w0.
  - E3: down, r0 w1.
  - E4: down, r1 w0.
  - E5: up, r0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE, start=1 at edge S:
  - busy=1, done=0, fail=0.
  - First command (E0, addr 0, write) is registered at the same edge S.
- RUN issues one command per cycle, no gaps:
  - E0 and E5: 1 cycle/address.
  - E1-E4: read cycle then write cycle per address.
  - Total 10N commands on edges S..S+10N-1.
- Address generator:
  - Up elements start at 0; down elements start at N-1.
  - Element advance happens when the address reaches its terminal value (wrap is never used).
- Commands:
  - Writes: sram_we=1, sram_wmask all ones.
  - Reads: sram_we=0, wmask=0.
- Read check:
  - A read registered at edge E is captured by the SRAM at E+1.
  - sram_dout is compared to the expected value at E+2.
  - A 2-deep shift register carries {valid, expected, elem, addr}.
- Mismatch (first only):
  - At the compare edge, latch fail_elem, fail_addr, fail_data; set fail=1.
  - Go to DONE: busy=0, done=1, sram_we=0 from that edge.
  - Up to 2 commands already registered after the faulting read still execute; this is permitted.
  - Later mismatches are ignored.
- End of run:
  - After the last E5 read, enter DRAIN with sram_we=0 until the pipeline empties.
  - done=1, busy=0 at edge S+10N+1.
- DONE:
  - Holds outputs; sram_we=0.
  - start=1 begins a new run exactly as from IDLE.
- start while busy: ignored.
- rst_n low mid-run: immediate return to reset values; no further SRAM writes.

Decomposition:
- Package sram_bist_pkg holds:
  - elem_t enum (E0..E5).
  - state_t enum.
  - Per-element constant tables: direction, has_read, read_val, write_val (1-bit logical values, mapped through DATA_BG).
- Sub-module sram_bist_addr_gen:
  - Loadable up/down counter of ADDR_WIDTH bits.
  - Inputs: load, dir, step.
  - Outputs: addr, last (terminal address reached).

Test Plan:
- Fault-free behavioral SRAM, N=1024, DATA_BG=0, start pulse at edge S -> exactly 10240 commands issued; done=1, fail=0 at S+10241; busy low one edge after the E5 drain.
- ADDR_WIDTH=3, DATA_BG=0x0000FFFF -> command trace matches the golden list (80 commands), including E3 addresses 7..0 and din=0xFFFF0000 for "1" writes.
- Bit 5 of addr 0x155 stuck-at-1 -> fail=1, fail_elem=1, fail_addr=0x155, fail_data=0x00000020, sram_we=0 from the fail edge.
- Bit 0 of addr 0x3FF stuck-at-0 -> fail_elem=2, fail_addr=0x3FF, fail_data=0xFFFFFFFE.
- start held high for the entire run, plus a second pulse mid-run -> single 10N-command run; a restart occurs only after done, with fail/done cleared on the accepting edge.
- rst_n asserted 500 cycles into E1 -> all outputs return to reset values asynchronously, no sram_we pulse afterwards; a new start runs a complete clean pass.

Source files
------------

// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element tables for the SRAM BIST.
// Element tables hold 1-bit logical values; the top maps them through the data background.
package sram_bist_pkg;

    typedef enum logic [2:0] {E0, E1, E2, E3, E4, E5} elem_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // Bit i of each table describes element Ei.
    localparam logic [5:0] ELEM_DOWN      = 6'b011000;
    localparam logic [5:0] ELEM_HAS_READ  = 6'b111110;
    localparam logic [5:0] ELEM_HAS_WRITE = 6'b011111;
    localparam logic [5:0] ELEM_READ_VAL  = 6'b010100;
    localparam logic [5:0] ELEM_WRITE_VAL = 6'b001010;

    function automatic logic elem_dir(elem_t e);
        return ELEM_DOWN[e];
    endfunction

    function automatic logic has_read(elem_t e);
        return ELEM_HAS_READ[e];
    endfunction

    function automatic logic has_write(elem_t e);
        return ELEM_HAS_WRITE[e];
    endfunction

    function automatic logic read_val(elem_t e);
        return ELEM_READ_VAL[e];
    endfunction

    function automatic logic write_val(elem_t e);
        return ELEM_WRITE_VAL[e];
    endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Loadable up/down address counter for the March elements.
// Direction is latched on load so 'last' never depends combinationally on the load decision.
module sram_bist_addr_gen
    import sram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  dir,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    logic down;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            down <= 1'b0;
        end else if (load) begin
            addr <= dir ? '1 : '0;
            down <= dir;
        end else if (step) begin
            addr <= down ? addr - ADDR_WIDTH'(1) : addr + ADDR_WIDTH'(1);
        end
    end

    assign last = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST initiator for one single-port SRAM: issues one command per cycle,
// checks read data two edges after issue and records the first failure.
module sram_march_bist
    import sram_bist_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 10,
    parameter int                    WMASK_WIDTH = 1,
    parameter logic [DATA_WIDTH-1:0] DATA_BG     = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   fail,
    output logic [2:0]             fail_elem,
    output logic [ADDR_WIDTH-1:0]  fail_addr,
    output logic [DATA_WIDTH-1:0]  fail_data,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);

    function automatic logic [DATA_WIDTH-1:0] bg_word(logic v);
        return v ? ~DATA_BG : DATA_BG;
    endfunction

    state_t state, state_nxt;
    elem_t  elem, elem_nxt;
    logic   phase, phase_nxt;       // 1 = current command is the element's write
    logic   load, step, gen_dir, last;
    logic   issue, issue_wr;
    logic   running, accept, mism;

    logic                  vld_p0, vld_p1;
    logic [DATA_WIDTH-1:0] exp_p1;
    elem_t                 elem_p1;
    logic [ADDR_WIDTH-1:0] addr_p1;

    sram_bist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .dir   (gen_dir),
        .step  (step),
        .addr  (sram_addr),
        .last  (last)
    );

    assign running = (state == RUN) || (state == DRAIN);
    assign accept  = start && ((state == IDLE) || (state == DONE));
    assign mism    = running && vld_p1 && (sram_dout != exp_p1);
    assign busy    = running;
    assign done    = (state == DONE);

    always_comb begin
        state_nxt = state;
        elem_nxt  = elem;
        phase_nxt = phase;
        load      = 1'b0;
        step      = 1'b0;
        gen_dir   = 1'b0;
        issue     = 1'b0;
        issue_wr  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    elem_nxt  = E0;
                    phase_nxt = 1'b1;
                    load      = 1'b1;
                    gen_dir   = elem_dir(E0);
                    issue     = 1'b1;
                    issue_wr  = 1'b1;
                end
            end
            RUN: begin
                if (mism) begin
                    state_nxt = DONE;
                end else if (!phase && has_write(elem)) begin
                    phase_nxt = 1'b1;
                    issue     = 1'b1;
                    issue_wr  = 1'b1;
                end else if (!last) begin
                    step      = 1'b1;
                    phase_nxt = !has_read(elem);
                    issue     = 1'b1;
                    issue_wr  = phase_nxt;
                end else if (elem == E5) begin
                    state_nxt = DRAIN;
                end else begin
                    elem_nxt  = elem_t'(elem + 3'd1);
                    load      = 1'b1;
                    gen_dir   = elem_dir(elem_nxt);
                    phase_nxt = !has_read(elem_nxt);
                    issue     = 1'b1;
                    issue_wr  = phase_nxt;
                end
            end
            DRAIN: begin
                // The last read is compared on the edge after p0 empties.
                if (mism || !vld_p0) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: command registers plus read-valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            elem       <= E0;
            phase      <= 1'b1;
            sram_we    <= 1'b0;
            sram_wmask <= '0;
            sram_din   <= '0;
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
            fail       <= 1'b0;
            fail_elem  <= '0;
            fail_addr  <= '0;
            fail_data  <= '0;
        end else begin
            state      <= state_nxt;
            elem       <= elem_nxt;
            phase      <= phase_nxt;
            sram_we    <= issue && issue_wr;
            sram_wmask <= {WMASK_WIDTH{issue && issue_wr}};
            if (issue && issue_wr) sram_din <= bg_word(write_val(elem_nxt));
            vld_p0     <= issue && !issue_wr;
            vld_p1     <= running && vld_p0;
            if (accept) fail <= 1'b0;
            if (mism) begin
                fail      <= 1'b1;
                fail_elem <= elem_p1;
                fail_addr <= addr_p1;
                fail_data <= sram_dout;
            end
        end
    end

    // Stage p1: expected data and location of the read issued one edge earlier
    always_ff @(posedge clk) begin
        exp_p1  <= bg_word(read_val(elem));
        elem_p1 <= elem;
        addr_p1 <= sram_addr;
    end

endmodule

// File: tb/tb_sram_march_bist.sv
// Directed bench for sram_march_bist: a 1024-word and an 8-word instance,
// each on a behavioural SRAM; the large one can inject stuck-at faults.
module tb_sram_march_bist;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int N  = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start;
    logic          busy, done, fail;
    logic [2:0]    fail_elem;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic          sram_we;
    logic [0:0]    sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din, sram_dout;

    logic          s_start, s_busy, s_done, s_fail, s_we;
    logic [2:0]    s_fail_elem;
    logic [2:0]    s_fail_addr;
    logic [DW-1:0] s_fail_data;
    logic [0:0]    s_wmask;
    logic [2:0]    s_addr;
    logic [DW-1:0] s_din, s_dout;

    int vectors = 0;
    int miscompares = 0;
    int fault_mode = 0;

    sram_march_bist dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .fail(fail),
        .fail_elem(fail_elem), .fail_addr(fail_addr), .fail_data(fail_data),
        .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout)
    );

    sram_march_bist #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .WMASK_WIDTH(1), .DATA_BG(32'h0000FFFF)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .busy(s_busy), .done(s_done), .fail(s_fail),
        .fail_elem(s_fail_elem), .fail_addr(s_fail_addr), .fail_data(s_fail_data),
        .sram_we(s_we), .sram_wmask(s_wmask), .sram_addr(s_addr),
        .sram_din(s_din), .sram_dout(s_dout)
    );

    logic [DW-1:0] mem [N];
    logic [DW-1:0] smem [8];

    function automatic logic [DW-1:0] faulty(logic [AW-1:0] a, logic [DW-1:0] d);
        if (fault_mode == 1 && a == 10'h155) return d | 32'h0000_0020;
        if (fault_mode == 2 && a == 10'h3FF) return d & 32'hFFFF_FFFE;
        return d;
    endfunction

    always @(posedge clk) begin
        if (sram_we) mem[sram_addr] <= sram_din;
        else         sram_dout <= faulty(sram_addr, mem[sram_addr]);
    end

    always @(posedge clk) begin
        if (s_we) smem[s_addr] <= s_din;
        else      s_dout <= smem[s_addr];
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Entered at the sample just after the accepting edge (index 0).
    task automatic run_until_done(input int limit, output int cyc, output int wr);
        cyc = 0;
        wr  = 0;
        while (!done && cyc < limit) begin
            if (sram_we) wr++;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; s_start = 1'b0; fault_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, fail, sram_we, sram_wmask} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b required 00000", {busy, done, fail, sram_we, sram_wmask});
        end
        vectors++;
        if (sram_addr !== '0 || sram_din !== '0) begin
            miscompares++;
            $display("FAIL reset_cmd: got addr=%h din=%h required 0/0", sram_addr, sram_din);
        end
        vectors++;
        if (fail_elem !== '0 || fail_addr !== '0 || fail_data !== '0) begin
            miscompares++;
            $display("FAIL reset_diag: got %h %h %h required zeros", fail_elem, fail_addr, fail_data);
        end
        vectors++;
        if ({s_busy, s_done, s_fail, s_we, s_fail_elem, s_fail_addr} !== 10'b0 || s_fail_data !== '0) begin
            miscompares++;
            $display("FAIL reset_small: got %b %h required zeros",
                     {s_busy, s_done, s_fail, s_we, s_fail_elem, s_fail_addr}, s_fail_data);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got busy=%b done=%b required 0/0", busy, done);
        end
    endtask

    task automatic test_small_trace();
        int e_down [6] = '{0, 0, 0, 1, 1, 0};
        int e_rd   [6] = '{0, 1, 1, 1, 1, 1};
        int e_wr   [6] = '{1, 1, 1, 1, 1, 0};
        int e_wv   [6] = '{0, 1, 0, 1, 0, 0};
        int k = 0;
        logic [2:0]  a;
        logic [31:0] d;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < 8; i++) begin
                a = (e_down[e] != 0) ? 3'(7 - i) : 3'(i);
                if (e_rd[e] != 0) begin
                    vectors++;
                    if (s_we !== 1'b0 || s_wmask !== 1'b0 || s_addr !== a) begin
                        miscompares++;
                        $display("FAIL trace_rd[%0d]: got we=%b addr=%0d required we=0 addr=%0d", k, s_we, s_addr, a);
                    end
                    @(posedge clk); #1;
                    k++;
                end
                if (e_wr[e] != 0) begin
                    d = (e_wv[e] != 0) ? 32'hFFFF0000 : 32'h0000FFFF;
                    vectors++;
                    if (s_we !== 1'b1 || s_wmask !== 1'b1 || s_addr !== a || s_din !== d) begin
                        miscompares++;
                        $display("FAIL trace_wr[%0d]: got we=%b addr=%0d din=%h required we=1 addr=%0d din=%h",
                                 k, s_we, s_addr, s_din, a, d);
                    end
                    @(posedge clk); #1;
                    k++;
                end
            end
        end
        vectors++;
        if (s_busy !== 1'b1 || s_done !== 1'b0 || s_we !== 1'b0) begin
            miscompares++;
            $display("FAIL small_drain: got busy=%b done=%b we=%b required 1/0/0", s_busy, s_done, s_we);
        end
        @(posedge clk); #1;
        vectors++;
        if (s_busy !== 1'b0 || s_done !== 1'b1 || s_fail !== 1'b0) begin
            miscompares++;
            $display("FAIL small_done: got busy=%b done=%b fail=%b required 0/1/0", s_busy, s_done, s_fail);
        end
    endtask

    task automatic test_clean_run();
        int cyc, wr;
        fault_mode = 0;
        pulse_start();
        run_until_done(10 * N, cyc, wr);
        vectors++;
        if (cyc !== 10 * N || busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL clean_drain: got cyc=%0d busy=%b done=%b required %0d/1/0", cyc, busy, done, 10 * N);
        end
        vectors++;
        if (wr !== 5 * N) begin
            miscompares++;
            $display("FAIL clean_writes: got %0d required %0d", wr, 5 * N);
        end
        @(posedge clk); #1;
        vectors++;
        if ({busy, done, fail, sram_we} !== 4'b0100) begin
            miscompares++;
            $display("FAIL clean_done: got busy/done/fail/we=%b required 0100", {busy, done, fail, sram_we});
        end
    endtask

    task automatic test_fault_sa1();
        int cyc, wr;
        fault_mode = 1;
        pulse_start();
        run_until_done(20000, cyc, wr);
        vectors++;
        if (cyc !== 1708) begin
            miscompares++;
            $display("FAIL sa1_time: got done at %0d required 1708", cyc);
        end
        vectors++;
        if (fail !== 1'b1 || fail_elem !== 3'd1 || fail_addr !== 10'h155 || fail_data !== 32'h00000020) begin
            miscompares++;
            $display("FAIL sa1_diag: got fail=%b elem=%0d addr=%h data=%h required 1/1/155/00000020",
                     fail, fail_elem, fail_addr, fail_data);
        end
        vectors++;
        if (sram_we !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL sa1_stop: got we=%b busy=%b required 0/0", sram_we, busy);
        end
    endtask

    task automatic test_fault_sa0();
        int cyc, wr;
        fault_mode = 2;
        pulse_start();
        run_until_done(20000, cyc, wr);
        vectors++;
        if (cyc !== 5120) begin
            miscompares++;
            $display("FAIL sa0_time: got done at %0d required 5120", cyc);
        end
        vectors++;
        if (fail !== 1'b1 || fail_elem !== 3'd2 || fail_addr !== 10'h3FF || fail_data !== 32'hFFFFFFFE) begin
            miscompares++;
            $display("FAIL sa0_diag: got fail=%b elem=%0d addr=%h data=%h required 1/2/3ff/fffffffe",
                     fail, fail_elem, fail_addr, fail_data);
        end
    endtask

    task automatic test_start_held();
        int cyc = 0;
        int wr = 0;
        fault_mode = 0;
        start = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (fail !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL held_accept: got fail=%b done=%b busy=%b required 0/0/1", fail, done, busy);
        end
        while (!done && cyc < 20000) begin
            if (sram_we) wr++;
            if (cyc == 3000) start = 1'b0;
            if (cyc == 3003) start = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        vectors++;
        if (cyc !== 10 * N + 1 || wr !== 5 * N || fail !== 1'b0) begin
            miscompares++;
            $display("FAIL held_single_run: got cyc=%0d wr=%0d fail=%b required %0d/%0d/0",
                     cyc, wr, fail, 10 * N + 1, 5 * N);
        end
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b1 || sram_we !== 1'b1 || sram_addr !== '0) begin
            miscompares++;
            $display("FAIL held_restart: got done=%b busy=%b we=%b addr=%h required 0/1/1/000",
                     done, busy, sram_we, sram_addr);
        end
        start = 1'b0;
    endtask

    // Continues the run restarted at the end of test_start_held.
    task automatic test_reset_mid_run();
        int cyc, wr;
        logic we_seen = 1'b0;
        repeat (N + 500) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, fail, sram_we, sram_wmask} !== 5'b0 || sram_addr !== '0 || sram_din !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got ctrl=%b addr=%h din=%h required zeros",
                     {busy, done, fail, sram_we, sram_wmask}, sram_addr, sram_din);
        end
        repeat (4) begin
            @(posedge clk); #1;
            if (sram_we) we_seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (sram_we) we_seen = 1'b1;
        end
        vectors++;
        if (we_seen !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_quiet: got we_seen=%b busy=%b required 0/0", we_seen, busy);
        end
        pulse_start();
        run_until_done(20000, cyc, wr);
        vectors++;
        if (cyc !== 10 * N + 1 || wr !== 5 * N || fail !== 1'b0) begin
            miscompares++;
            $display("FAIL rerun_after_reset: got cyc=%0d wr=%0d fail=%b required %0d/%0d/0",
                     cyc, wr, fail, 10 * N + 1, 5 * N);
        end
    endtask

    initial begin
        test_reset();
        test_small_trace();
        test_clean_run();
        test_fault_sa1();
        test_fault_sa0();
        test_start_held();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
